// File: rtl/c3lib_ckmux4_switch_ctl.sv
// Glitch-free select sequencer for a 4:1 clock mux: gates the mux output off,
// waits for in-flight edges to drain, moves both select bits together, then re-enables.
module c3lib_ckmux4_switch_ctl #(
    parameter int unsigned GATE_DLY   = 4,
    parameter int unsigned SETTLE_DLY = 4,
    parameter logic [1:0]  RST_SEL    = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel_req,
    input  logic       sel_req_vld,
    output logic       sel_req_rdy,
    output logic       sel_ack,
    output logic       mux_s0,
    output logic       mux_s1,
    output logic       ck_gate_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        SETTLE = 2'b10
    } state_t;

    localparam logic [7:0] GATE_LOAD   = 8'(GATE_DLY - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_DLY - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] target_q, target_d;
    logic       gate_q, gate_d;
    logic       ack_q, ack_d;
    logic       rdy_q, rdy_d;
    logic       busy_q, busy_d;
    logic       rst_exit_q, rst_exit_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        target_d   = target_q;
        gate_d     = gate_q;
        ack_d      = 1'b0;
        rst_exit_d = rst_exit_q;
        case (state_q)
            IDLE: begin
                if (sel_req_vld) begin
                    if (sel_req == sel_q) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d  = DRAIN;
                        gate_d   = 1'b0;
                        cnt_d    = GATE_LOAD;
                        target_d = sel_req;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 8'd0) begin
                    sel_d   = target_q;
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SETTLE: begin
                // The settle that follows reset completes silently; only requests are acked.
                if (cnt_q == 8'd0) begin
                    state_d    = IDLE;
                    gate_d     = 1'b1;
                    ack_d      = ~rst_exit_q;
                    rst_exit_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d    = SETTLE;
                gate_d     = 1'b0;
                cnt_d      = SETTLE_LOAD;
                rst_exit_d = 1'b1;
            end
        endcase
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SETTLE;
            cnt_q      <= SETTLE_LOAD;
            sel_q      <= RST_SEL;
            target_q   <= RST_SEL;
            gate_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
            rst_exit_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            target_q   <= target_d;
            gate_q     <= gate_d;
            ack_q      <= ack_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            rst_exit_q <= rst_exit_d;
        end
    end

    assign sel_req_rdy = rdy_q;
    assign sel_ack     = ack_q;
    assign mux_s0      = sel_q[0];
    assign mux_s1      = sel_q[1];
    assign ck_gate_en  = gate_q;
    assign busy        = busy_q;

endmodule
